depar_pipe_arbiter: RTL and testbench
=====================================

// Module: depar_pipe_arbiter
// PURPOSE
//  Shares one deparser (depar_do_deparsing) between N_PIPES match-action pipelines; each pipeline has its own pkt FIFO and PHV FIFO.
//  Packet-granular round-robin: a grant holds until its PHV is read and its pkt FIFO is read through tlast.
//  Sits between the per-pipeline FIFOs and the deparser's pkt_fifo_* / phv_fifo_* inputs.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256         pkt data width (tkeep = /8)
//  C_AXIS_TUSER_WIDTH  128         pkt tuser width
//  C_PKT_VEC_WIDTH     4*64*8+256  PHV width (2304)
//  N_PIPES             2           number of requesting pipelines (2..8)
//  C_SEL_WIDTH         3           grant index width, >= clog2(N_PIPES)
// PORTS
//  axis_clk             in   1                       clock
//  areset               in   1                       asynchronous active-high reset
//  s_pkt_tdata          in   N_PIPES*DATA            flattened, pipe i at [i*W +: W]
//  s_pkt_tkeep          in   N_PIPES*DATA/8          per-pipe tkeep
//  s_pkt_tuser          in   N_PIPES*TUSER           per-pipe tuser
//  s_pkt_tlast          in   N_PIPES                 per-pipe tlast
//  s_pkt_empty          in   N_PIPES                 per-pipe pkt FIFO empty
//  s_pkt_rd_en          out  N_PIPES                 per-pipe pkt FIFO read
//  s_phv_out            in   N_PIPES*C_PKT_VEC_WIDTH per-pipe PHV
//  s_phv_empty          in   N_PIPES                 per-pipe PHV FIFO empty
//  s_phv_rd_en          out  N_PIPES                 per-pipe PHV FIFO read
//  pkt_fifo_tdata/tkeep/tuser/tlast  out  as above   muxed to deparser
//  pkt_fifo_empty       out  1                       to deparser
//  pkt_fifo_rd_en       in   1                       from deparser
//  phv_fifo_out         out  C_PKT_VEC_WIDTH         muxed to deparser
//  phv_fifo_empty       out  1                       to deparser
//  phv_fifo_rd_en       in   1                       from deparser
//  grant_id             out  C_SEL_WIDTH             current/last granted pipe
//  arb_busy             out  1                       1 while in BUSY
//  err_phv_overrun      out  1                       sticky: 2nd PHV read in one grant
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rr_ptr=0, grant_id=0, phv_done=0, arb_busy=0, err_phv_overrun=0;
//   all s_*_rd_en=0, pkt_fifo_empty=1, phv_fifo_empty=1. Reset mid-packet abandons the grant; nothing is replayed.
//  Eligible(i) = !s_pkt_empty[i] & !s_phv_empty[i].
//  IDLE: deparser sees both empties=1. If any pipe eligible, pick first eligible searching rr_ptr, rr_ptr+1, ... (mod N_PIPES);
//   register grant_id, phv_done=0, go BUSY next edge. Grant latency: 1 cycle from eligibility to BUSY.
//  BUSY: data muxes select grant_id (combinational); pkt_fifo_empty=s_pkt_empty[g], phv_fifo_empty=s_phv_empty[g] OR phv_done.
//   s_pkt_rd_en[g]=pkt_fifo_rd_en, s_phv_rd_en[g]=phv_fifo_rd_en & !phv_done; all other rd_en=0.
//   phv_fifo_rd_en sets phv_done; phv_fifo_rd_en while phv_done=1 sets err_phv_overrun and is not forwarded.
//  Release: pkt_fifo_rd_en & pkt_fifo_tlast & (phv_done | phv_fifo_rd_en same cycle) -> IDLE; rr_ptr=grant_id+1 (wraps to 0 at N_PIPES).
//   tlast read before PHV read: stay BUSY, pkt_fifo_empty forced 1 until PHV read, then release.
//  Reads gated by deparser only; arbiter never reads on its own. Rd_en in IDLE ignored.
//  Back-to-back packets on one pipe: at least 1 IDLE cycle between grants (no bubble-free same-pipe chaining).
//  Simultaneous eligibility: strict rotation from rr_ptr; no pipe waits more than N_PIPES-1 packets.
//  grant_id holds its value in IDLE until the next grant.
// TESTING
//  1. Pipe 0 only, 3-beat pkt + PHV -> grant_id=0 one cycle after eligible; 3 beats out in order; rr_ptr=1; IDLE after tlast.
//  2. N_PIPES=2, both always eligible, 4 pkts each -> grants alternate 0,1,0,1...; no beats interleaved within a packet.
//  3. Pipe 1 PHV empty, pkt present -> never granted; pipe 0 served; pipe 1 granted the cycle after its PHV arrives.
//  4. Deparser reads tlast before PHV -> stays BUSY, pkt_fifo_empty=1; after PHV read -> IDLE next edge.
//  5. Two phv_fifo_rd_en in one grant -> 2nd not forwarded to s_phv_rd_en; err_phv_overrun=1 until reset.
//  6. areset asserted mid-packet on pipe 1 -> all outputs at reset values immediately; next grant searches from pipe 0.

Source files
------------

// File: rtl/depar_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// depar_pipe_arbiter
//
// Shares one deparser between N_PIPES match-action pipelines. Each pipeline
// owns a packet FIFO and a PHV FIFO. A pipeline may be granted only when both
// of its FIFOs are non-empty. Arbitration is packet-granular round-robin: a
// grant lasts until its PHV has been read once and its packet has been read
// through tlast. At least one IDLE cycle separates any two grants.
//
// Ports
//   axis_clk, areset          clock, asynchronous active-high reset
//   s_pkt_tdata/tkeep/tuser   per-pipe packet FIFO heads (pipe i at [i*W +: W])
//   s_pkt_tlast, s_pkt_empty  per-pipe packet FIFO tlast / empty
//   s_pkt_rd_en               per-pipe packet FIFO read strobes
//   s_phv_out, s_phv_empty    per-pipe PHV FIFO head / empty
//   s_phv_rd_en               per-pipe PHV FIFO read strobes
//   pkt_fifo_*                muxed packet FIFO view presented to the deparser
//   phv_fifo_*                muxed PHV FIFO view presented to the deparser
//   grant_id                  current (BUSY) or last (IDLE) granted pipe
//   arb_busy                  high while a grant is active
//   err_phv_overrun           sticky: second PHV read attempted in one grant
// -----------------------------------------------------------------------------
module depar_pipe_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_PKT_VEC_WIDTH    = 4*64*8+256,
    parameter int N_PIPES            = 2,
    parameter int C_SEL_WIDTH        = 3
) (
    input  logic                                       axis_clk,
    input  logic                                       areset,

    input  logic [N_PIPES*C_AXIS_DATA_WIDTH-1:0]       s_pkt_tdata,
    input  logic [N_PIPES*(C_AXIS_DATA_WIDTH/8)-1:0]   s_pkt_tkeep,
    input  logic [N_PIPES*C_AXIS_TUSER_WIDTH-1:0]      s_pkt_tuser,
    input  logic [N_PIPES-1:0]                         s_pkt_tlast,
    input  logic [N_PIPES-1:0]                         s_pkt_empty,
    output logic [N_PIPES-1:0]                         s_pkt_rd_en,
    input  logic [N_PIPES*C_PKT_VEC_WIDTH-1:0]         s_phv_out,
    input  logic [N_PIPES-1:0]                         s_phv_empty,
    output logic [N_PIPES-1:0]                         s_phv_rd_en,

    output logic [C_AXIS_DATA_WIDTH-1:0]               pkt_fifo_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]             pkt_fifo_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]              pkt_fifo_tuser,
    output logic                                       pkt_fifo_tlast,
    output logic                                       pkt_fifo_empty,
    input  logic                                       pkt_fifo_rd_en,
    output logic [C_PKT_VEC_WIDTH-1:0]                 phv_fifo_out,
    output logic                                       phv_fifo_empty,
    input  logic                                       phv_fifo_rd_en,

    output logic [C_SEL_WIDTH-1:0]                     grant_id,
    output logic                                       arb_busy,
    output logic                                       err_phv_overrun
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q,    state_d;
    logic [C_SEL_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
    logic [C_SEL_WIDTH-1:0] grant_q,    grant_d;
    logic                   phv_done_q, phv_done_d;
    logic                   pkt_done_q, pkt_done_d;   // tlast consumed, waiting for PHV
    logic                   err_q,      err_d;

    logic [N_PIPES-1:0]     eligible;
    logic [N_PIPES-1:0]     grant_onehot;
    logic                   sel_pkt_empty;
    logic                   sel_phv_empty;
    logic                   found;
    logic [C_SEL_WIDTH-1:0] pick;
    logic                   pkt_rd;
    logic                   phv_rd;
    logic                   pkt_end;
    logic                   phv_seen;

    assign eligible = ~s_pkt_empty & ~s_phv_empty;

    // Data path: every deparser-facing field follows the registered grant.
    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block so no path can leave it unassigned and infer a latch.
    always_comb begin
        pkt_fifo_tdata = '0;
        pkt_fifo_tkeep = '0;
        pkt_fifo_tuser = '0;
        pkt_fifo_tlast = 1'b0;
        phv_fifo_out   = '0;
        sel_pkt_empty  = 1'b1;
        sel_phv_empty  = 1'b1;
        grant_onehot   = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            if (grant_q == C_SEL_WIDTH'(i)) begin
                pkt_fifo_tdata  = s_pkt_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                pkt_fifo_tkeep  = s_pkt_tkeep[i*KW +: KW];
                pkt_fifo_tuser  = s_pkt_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
                pkt_fifo_tlast  = s_pkt_tlast[i];
                phv_fifo_out    = s_phv_out[i*C_PKT_VEC_WIDTH +: C_PKT_VEC_WIDTH];
                sel_pkt_empty   = s_pkt_empty[i];
                sel_phv_empty   = s_phv_empty[i];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Round-robin search: first eligible pipe starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N_PIPES; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_PIPES) begin
                idx = idx - N_PIPES;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = C_SEL_WIDTH'(idx);
            end
        end
    end

    // Next-state and read-strobe routing.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        phv_done_d     = phv_done_q;
        pkt_done_d     = pkt_done_q;
        err_d          = err_q;
        s_pkt_rd_en    = '0;
        s_phv_rd_en    = '0;
        pkt_fifo_empty = 1'b1;
        phv_fifo_empty = 1'b1;
        pkt_rd         = 1'b0;
        phv_rd         = 1'b0;
        pkt_end        = 1'b0;
        phv_seen       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Deparser reads are ignored here; it sees both FIFOs empty.
                if (found) begin
                    grant_d    = pick;
                    phv_done_d = 1'b0;
                    pkt_done_d = 1'b0;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Once tlast has gone out, hide the packet FIFO so the next
                // packet of the same pipe cannot leak into this grant.
                pkt_fifo_empty = sel_pkt_empty | pkt_done_q;
                phv_fifo_empty = sel_phv_empty | phv_done_q;

                pkt_rd = pkt_fifo_rd_en & ~pkt_done_q;
                phv_rd = phv_fifo_rd_en & ~phv_done_q;

                if (pkt_rd) s_pkt_rd_en = grant_onehot;
                if (phv_rd) s_phv_rd_en = grant_onehot;

                if (phv_fifo_rd_en && phv_done_q) begin
                    err_d = 1'b1;
                end
                if (phv_rd) begin
                    phv_done_d = 1'b1;
                end
                if (pkt_rd && pkt_fifo_tlast) begin
                    pkt_done_d = 1'b1;
                end

                pkt_end  = pkt_done_q | (pkt_rd & pkt_fifo_tlast);
                phv_seen = phv_done_q | phv_rd;
                if (pkt_end && phv_seen) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == C_SEL_WIDTH'(N_PIPES - 1)) ? '0 : grant_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            phv_done_q <= 1'b0;
            pkt_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            phv_done_q <= phv_done_d;
            pkt_done_q <= pkt_done_d;
            err_q      <= err_d;
        end
    end

    assign grant_id        = grant_q;
    assign arb_busy        = (state_q == ST_BUSY);
    assign err_phv_overrun = err_q;

endmodule

// File: tb/tb_depar_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_depar_pipe_arbiter
//
// Bench-side FIFO models feed the arbiter; a simple deparser model drains it.
// Every packet loaded pushes its beats and PHV onto expected queues in the
// order the arbiter is expected to serve them; a separate monitor pops and
// compares each time the deparser actually consumes a beat or a PHV.
// -----------------------------------------------------------------------------
module tb_depar_pipe_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 8;
    localparam int PW = 16;
    localparam int SW = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            pipe;
    } beat_t;

    typedef struct {
        logic [PW-1:0] v;
        int            pipe;
    } phv_t;

    logic              clk;
    logic              areset;
    logic [NP*DW-1:0]  s_pkt_tdata;
    logic [NP*KW-1:0]  s_pkt_tkeep;
    logic [NP*UW-1:0]  s_pkt_tuser;
    logic [NP-1:0]     s_pkt_tlast;
    logic [NP-1:0]     s_pkt_empty;
    logic [NP-1:0]     s_pkt_rd_en;
    logic [NP*PW-1:0]  s_phv_out;
    logic [NP-1:0]     s_phv_empty;
    logic [NP-1:0]     s_phv_rd_en;
    logic [DW-1:0]     pkt_fifo_tdata;
    logic [KW-1:0]     pkt_fifo_tkeep;
    logic [UW-1:0]     pkt_fifo_tuser;
    logic              pkt_fifo_tlast;
    logic              pkt_fifo_empty;
    logic              pkt_fifo_rd_en;
    logic [PW-1:0]     phv_fifo_out;
    logic              phv_fifo_empty;
    logic              phv_fifo_rd_en;
    logic [SW-1:0]     grant_id;
    logic              arb_busy;
    logic              err_phv_overrun;

    depar_pipe_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_PKT_VEC_WIDTH    (PW),
        .N_PIPES            (NP),
        .C_SEL_WIDTH        (SW)
    ) dut (
        .axis_clk        (clk),
        .areset          (areset),
        .s_pkt_tdata     (s_pkt_tdata),
        .s_pkt_tkeep     (s_pkt_tkeep),
        .s_pkt_tuser     (s_pkt_tuser),
        .s_pkt_tlast     (s_pkt_tlast),
        .s_pkt_empty     (s_pkt_empty),
        .s_pkt_rd_en     (s_pkt_rd_en),
        .s_phv_out       (s_phv_out),
        .s_phv_empty     (s_phv_empty),
        .s_phv_rd_en     (s_phv_rd_en),
        .pkt_fifo_tdata  (pkt_fifo_tdata),
        .pkt_fifo_tkeep  (pkt_fifo_tkeep),
        .pkt_fifo_tuser  (pkt_fifo_tuser),
        .pkt_fifo_tlast  (pkt_fifo_tlast),
        .pkt_fifo_empty  (pkt_fifo_empty),
        .pkt_fifo_rd_en  (pkt_fifo_rd_en),
        .phv_fifo_out    (phv_fifo_out),
        .phv_fifo_empty  (phv_fifo_empty),
        .phv_fifo_rd_en  (phv_fifo_rd_en),
        .grant_id        (grant_id),
        .arb_busy        (arb_busy),
        .err_phv_overrun (err_phv_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench FIFO contents and scoreboard queues.
    beat_t pq[NP][$];
    logic [PW-1:0] hq[NP][$];
    beat_t exp_beats[$];
    phv_t  exp_phv[$];

    int n_vec = 0;
    int n_mis = 0;
    int serial = 0;

    // Deparser model controls.
    logic dep_en    = 1'b0;
    logic phv_allow = 1'b1;
    logic man_pkt   = 1'b0;
    logic man_phv   = 1'b0;
    logic [NP-1:0] cap_pkt;
    logic [NP-1:0] cap_phv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            if (pq[i].size() > 0) begin
                s_pkt_tdata[i*DW +: DW] = pq[i][0].data;
                s_pkt_tkeep[i*KW +: KW] = pq[i][0].keep;
                s_pkt_tuser[i*UW +: UW] = pq[i][0].user;
                s_pkt_tlast[i]          = pq[i][0].last;
                s_pkt_empty[i]          = 1'b0;
            end else begin
                s_pkt_tdata[i*DW +: DW] = '0;
                s_pkt_tkeep[i*KW +: KW] = '0;
                s_pkt_tuser[i*UW +: UW] = '0;
                s_pkt_tlast[i]          = 1'b0;
                s_pkt_empty[i]          = 1'b1;
            end
            if (hq[i].size() > 0) begin
                s_phv_out[i*PW +: PW] = hq[i][0];
                s_phv_empty[i]        = 1'b0;
            end else begin
                s_phv_out[i*PW +: PW] = '0;
                s_phv_empty[i]        = 1'b1;
            end
        end
    endtask

    task automatic load_phv(input int pipe, input int ser);
        phv_t p;
        p.v    = {4'(pipe), 8'(ser), 4'hA};
        p.pipe = pipe;
        hq[pipe].push_back(p.v);
        exp_phv.push_back(p);
        refresh();
    endtask

    // Loads one packet; call order across pipes equals expected service order.
    task automatic load_pkt(input int pipe, input int nbeats, input logic with_phv);
        beat_t b;
        serial++;
        for (int k = 0; k < nbeats; k++) begin
            b.data = {8'(pipe), 8'(serial), 8'(k), 8'hD0};
            b.last = (k == nbeats - 1);
            b.keep = b.last ? 4'h3 : 4'hF;
            b.user = 8'(serial * 3 + k);
            b.pipe = pipe;
            pq[pipe].push_back(b);
            exp_beats.push_back(b);
        end
        if (with_phv) load_phv(pipe, serial);
        refresh();
    endtask

    // One clock: deparser decides at negedge, FIFOs pop just after posedge.
    task automatic step();
        @(negedge clk);
        if (dep_en) begin
            pkt_fifo_rd_en = !pkt_fifo_empty;
            phv_fifo_rd_en = phv_allow && !phv_fifo_empty;
        end else begin
            pkt_fifo_rd_en = man_pkt;
            phv_fifo_rd_en = man_phv;
        end
        #3;
        cap_pkt = s_pkt_rd_en;
        cap_phv = s_phv_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (cap_pkt[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (cap_phv[i] && hq[i].size() > 0) void'(hq[i].pop_front());
        end
        refresh();
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !(exp_beats.size() == 0 && exp_phv.size() == 0 && !arb_busy)) begin
            step();
            c++;
        end
        check(name, 64'({arb_busy, 8'(exp_beats.size()), 8'(exp_phv.size())}), 64'(0));
    endtask

    task automatic wait_busy(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !arb_busy) begin
            step();
            c++;
        end
        check(name, 64'(arb_busy), 64'(1));
    endtask

    // Monitor: compares whatever the deparser really consumes this cycle.
    initial begin
        beat_t eb;
        phv_t  ep;
        forever begin
            @(negedge clk);
            #2;
            if (!areset && pkt_fifo_rd_en && !pkt_fifo_empty) begin
                if (exp_beats.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL beat_unexpected: got %0h with nothing expected at %0t", pkt_fifo_tdata, $time);
                end else begin
                    eb = exp_beats.pop_front();
                    check("beat", 64'({pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_tdata}),
                          64'({eb.keep, eb.user, eb.last, eb.data}));
                    check("beat_route", 64'(s_pkt_rd_en), 64'(1) << eb.pipe);
                end
            end
            if (!areset && phv_fifo_rd_en && !phv_fifo_empty) begin
                if (exp_phv.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL phv_unexpected: got %0h with nothing expected at %0t", phv_fifo_out, $time);
                end else begin
                    ep = exp_phv.pop_front();
                    check("phv", 64'(phv_fifo_out), 64'(ep.v));
                    check("phv_route", 64'(s_phv_rd_en), 64'(1) << ep.pipe);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        areset         = 1'b1;
        pkt_fifo_rd_en = 1'b1;
        phv_fifo_rd_en = 1'b1;
        refresh();
        #3;
        // Reset values, with the deparser trying to read.
        check("rst_busy",      64'(arb_busy), 64'(0));
        check("rst_grant",     64'(grant_id), 64'(0));
        check("rst_err",       64'(err_phv_overrun), 64'(0));
        check("rst_empties",   64'({pkt_fifo_empty, phv_fifo_empty}), 64'(2'b11));
        check("rst_rd_en",     64'({s_pkt_rd_en, s_phv_rd_en}), 64'(0));
        pkt_fifo_rd_en = 1'b0;
        phv_fifo_rd_en = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // 1: single pipe, 3-beat packet; grant follows eligibility by one edge.
        load_pkt(0, 3, 1'b1);
        check("t1_no_grant_yet", 64'(arb_busy), 64'(0));
        step();
        check("t1_busy",  64'(arb_busy), 64'(1));
        check("t1_grant", 64'(grant_id), 64'(0));
        check("t1_idle_empty", 64'(pkt_fifo_empty), 64'(0));
        dep_en = 1'b1;
        drain("t1_drain", 20);
        check("t1_grant_hold", 64'(grant_id), 64'(0));

        // 2: both pipes loaded; rr_ptr is 1 after test 1, so service is 1,0,1,0...
        dep_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            load_pkt(1, 1 + (k + 1) % 3, 1'b1);
            load_pkt(0, 1 + k % 3, 1'b1);
        end
        dep_en = 1'b1;
        drain("t2_drain", 200);

        // 3: pipe 1 lacks a PHV, so only pipe 0 is served until it arrives.
        load_pkt(0, 2, 1'b1);
        load_pkt(1, 2, 1'b0);
        c = 0;
        while (c < 30 && !(pq[0].size() == 0 && !arb_busy)) begin
            step();
            c++;
        end
        check("t3_pipe0_done", 64'({8'(pq[0].size()), arb_busy}), 64'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_pipe1_blocked", 64'(arb_busy), 64'(0));
        end
        dep_en = 1'b0;
        load_phv(1, serial);
        check("t3_phv_arrival", 64'(arb_busy), 64'(0));
        step();
        check("t3_busy",  64'(arb_busy), 64'(1));
        check("t3_grant", 64'(grant_id), 64'(1));
        dep_en = 1'b1;
        drain("t3_drain", 20);

        // 4: tlast read before PHV; a second packet waits behind it on pipe 0.
        phv_allow = 1'b0;
        load_pkt(0, 2, 1'b1);
        load_pkt(0, 2, 1'b1);
        c = 0;
        while (c < 20 && pq[0].size() != 2) begin
            step();
            c++;
        end
        step();
        check("t4_held_busy",  64'(arb_busy), 64'(1));
        check("t4_pkt_hidden", 64'(pkt_fifo_empty), 64'(1));
        check("t4_phv_avail",  64'(phv_fifo_empty), 64'(0));
        check("t4_no_leak",    64'(pq[0].size()), 64'(2));
        phv_allow = 1'b1;
        step();
        check("t4_release", 64'(arb_busy), 64'(0));
        drain("t4_drain", 30);

        // 5: second PHV read within one grant (rr_ptr is 1 after test 4).
        dep_en = 1'b0;
        load_pkt(1, 2, 1'b1);
        hq[1].push_back(16'hBEEF);
        refresh();
        wait_busy("t5_busy", 10);
        check("t5_grant", 64'(grant_id), 64'(1));
        man_phv = 1'b1;
        step();
        check("t5_first_read", 64'({8'(hq[1].size()), err_phv_overrun}), 64'({8'd1, 1'b0}));
        step();
        check("t5_not_forwarded", 64'(hq[1].size()), 64'(1));
        check("t5_err_set", 64'(err_phv_overrun), 64'(1));
        man_phv = 1'b0;
        dep_en  = 1'b1;
        drain("t5_drain", 20);
        check("t5_err_sticky", 64'(err_phv_overrun), 64'(1));
        hq[1].delete();
        refresh();

        // 6: reset mid-packet on pipe 1 (pipe 0 is served first from rr_ptr 0).
        load_pkt(0, 1, 1'b1);
        load_pkt(1, 3, 1'b1);
        c = 0;
        while (c < 30 && pq[1].size() != 2) begin
            step();
            c++;
        end
        check("t6_mid_pkt", 64'({arb_busy, 5'(grant_id)}), 64'({1'b1, 5'd1}));
        dep_en         = 1'b0;
        pkt_fifo_rd_en = 1'b0;
        phv_fifo_rd_en = 1'b0;
        @(negedge clk);
        #3;
        pkt_fifo_rd_en = 1'b1;
        phv_fifo_rd_en = 1'b1;
        #1;
        areset = 1'b1;
        #1;
        check("t6_rst_busy",    64'(arb_busy), 64'(0));
        check("t6_rst_grant",   64'(grant_id), 64'(0));
        check("t6_rst_err",     64'(err_phv_overrun), 64'(0));
        check("t6_rst_empties", 64'({pkt_fifo_empty, phv_fifo_empty}), 64'(2'b11));
        check("t6_rst_rd_en",   64'({s_pkt_rd_en, s_phv_rd_en}), 64'(0));
        pkt_fifo_rd_en = 1'b0;
        phv_fifo_rd_en = 1'b0;
        for (int i = 0; i < NP; i++) begin
            pq[i].delete();
            hq[i].delete();
        end
        exp_beats.delete();
        exp_phv.delete();
        refresh();
        @(negedge clk);
        #1;
        areset = 1'b0;
        @(posedge clk);
        #1;
        load_pkt(0, 1, 1'b1);
        load_pkt(1, 1, 1'b1);
        wait_busy("t6_regrant", 10);
        check("t6_grant_from_0", 64'(grant_id), 64'(0));
        dep_en = 1'b1;
        drain("t6_drain", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
